// File: rtl/cg_vector_bank_if.sv
// ALU-side bus of one double-buffered CG vector bank (read, write, swap and
// previous-iteration ports). The ALU drives the master modport, the bank is the slave.
interface cg_vector_bank_if #(
  parameter int element_width = 32,
  parameter int no_of_units   = 8
);
  localparam int beat_width = element_width * no_of_units;

  logic [31:0]           total;
  logic                  rd_req;
  logic                  rd_restart;
  logic [beat_width-1:0] rd_data;
  logic                  rd_valid;
  logic                  rd_done;
  logic                  wr_en;
  logic [beat_width-1:0] wr_data;
  logic                  wr_done;
  logic                  wr_overflow;
  logic                  swap;
  logic                  bank_sel;
  logic                  prev_req;
  logic [beat_width-1:0] prev_data;
  logic                  prev_valid;

  modport master (
    output total, rd_req, rd_restart, wr_en, wr_data, swap, prev_req,
    input  rd_data, rd_valid, rd_done, wr_done, wr_overflow, bank_sel,
           prev_data, prev_valid
  );

  modport slave (
    input  total, rd_req, rd_restart, wr_en, wr_data, swap, prev_req,
    output rd_data, rd_valid, rd_done, wr_done, wr_overflow, bank_sel,
           prev_data, prev_valid
  );
endinterface

// File: rtl/cg_vector_bank.sv
// Double-buffered CG vector store: reads come from the active bank, writes land in the
// shadow bank, swap exchanges them. Optional shadow-bank read port: CG_VBANK_PREV_PORT_EN.
module cg_vector_bank #(
  parameter int element_width = 32,
  parameter int no_of_units   = 8,
  parameter int memory_height = 1000,
  parameter int address_width = $clog2(memory_height) + 1
) (
  input  logic             clk,
  input  logic             reset,
  cg_vector_bank_if.slave  bus
);
  localparam int beat_width = element_width * no_of_units;
  localparam int idx_width  = $clog2(memory_height);
  localparam logic [31:0] height_w = 32'(memory_height);
  localparam logic [address_width-1:0] ptr_one = address_width'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    DONE = 2'd2
  } rd_state_t;

  logic [beat_width-1:0] mem_r [0:1][0:memory_height-1];

  rd_state_t             state_r, state_next_s, eff_state_s;
  logic [address_width-1:0] rd_ptr_r, rd_ptr_next_s, eff_ptr_s, rd_addr_s;
  logic [address_width-1:0] wr_ptr_r, wr_ptr_next_s;
  logic [31:0]           beats_r, beats_sample_s, quot_s;
  logic                  bank_sel_r, shadow_sel_s;
  logic                  rd_issue_s, wr_accept_s, wr_reject_s;
  logic [beat_width-1:0] rd_data_r;
  logic                  rd_valid_r, rd_done_r, wr_done_r, wr_overflow_r;

  // Beat count from total, clamped to the bank depth so pointers stay in range
  always_comb begin
    quot_s = bus.total / 32'(no_of_units);
    if (quot_s > height_w) begin
      beats_sample_s = height_w;
    end else begin
      beats_sample_s = quot_s;
    end
  end

  assign shadow_sel_s = ~bank_sel_r;

  // Read FSM next state; a restart is folded in as an IDLE/beat-0 starting point
  always_comb begin
    state_next_s  = state_r;
    rd_ptr_next_s = rd_ptr_r;
    eff_state_s   = state_r;
    eff_ptr_s     = rd_ptr_r;
    rd_addr_s     = rd_ptr_r;
    rd_issue_s    = 1'b0;
    if (bus.swap || reset) begin
      state_next_s  = IDLE;
      rd_ptr_next_s = '0;
    end else begin
      if (bus.rd_restart) begin
        eff_state_s = IDLE;
        eff_ptr_s   = '0;
      end else begin
        eff_state_s = state_r;
        eff_ptr_s   = rd_ptr_r;
      end
      state_next_s  = eff_state_s;
      rd_ptr_next_s = eff_ptr_s;
      rd_addr_s     = eff_ptr_s;
      case (eff_state_s)
        IDLE, READ: begin
          if (beats_r == 32'd0) begin
            state_next_s = DONE;
          end else if (bus.rd_req) begin
            rd_issue_s    = 1'b1;
            rd_ptr_next_s = eff_ptr_s + ptr_one;
            if (32'(eff_ptr_s) + 32'd1 >= beats_r) begin
              state_next_s = DONE;
            end else begin
              state_next_s = READ;
            end
          end else begin
            state_next_s = eff_state_s;
          end
        end
        DONE:    state_next_s = DONE;
        default: state_next_s = IDLE;
      endcase
    end
  end

  // Write-side acceptance: swap drops the beat, a full shadow bank flags overflow
  always_comb begin
    wr_accept_s   = 1'b0;
    wr_reject_s   = 1'b0;
    wr_ptr_next_s = wr_ptr_r;
    if (bus.wr_en && !bus.swap && !reset) begin
      if (32'(wr_ptr_r) < beats_r) begin
        wr_accept_s   = 1'b1;
        wr_ptr_next_s = wr_ptr_r + ptr_one;
      end else begin
        wr_reject_s = 1'b1;
      end
    end else begin
      wr_accept_s = 1'b0;
    end
  end

  // Control state and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= IDLE;
      rd_ptr_r      <= '0;
      wr_ptr_r      <= '0;
      bank_sel_r    <= 1'b0;
      beats_r       <= beats_sample_s;
      rd_data_r     <= '0;
      rd_valid_r    <= 1'b0;
      rd_done_r     <= 1'b0;
      wr_done_r     <= 1'b0;
      wr_overflow_r <= 1'b0;
    end else begin
      state_r       <= state_next_s;
      rd_ptr_r      <= rd_ptr_next_s;
      rd_valid_r    <= rd_issue_s;
      rd_done_r     <= (state_next_s == DONE);
      wr_overflow_r <= wr_overflow_r | wr_reject_s;
      if (rd_issue_s) begin
        rd_data_r <= mem_r[bank_sel_r][idx_width'(rd_addr_s)];
      end else begin
        rd_data_r <= rd_data_r;
      end
      if (bus.swap) begin
        bank_sel_r <= ~bank_sel_r;
        wr_ptr_r   <= '0;
        beats_r    <= beats_sample_s;
        wr_done_r  <= (beats_sample_s == 32'd0);
      end else begin
        wr_ptr_r  <= wr_ptr_next_s;
        wr_done_r <= (32'(wr_ptr_next_s) == beats_r);
      end
    end
  end

  // Shadow-bank write port; contents survive reset
  always_ff @(posedge clk) begin
    if (wr_accept_s) begin
      mem_r[shadow_sel_s][idx_width'(wr_ptr_r)] <= bus.wr_data;
    end
  end

  assign bus.rd_data     = rd_data_r;
  assign bus.rd_valid    = rd_valid_r;
  assign bus.rd_done     = rd_done_r;
  assign bus.wr_done     = wr_done_r;
  assign bus.wr_overflow = wr_overflow_r;
  assign bus.bank_sel    = bank_sel_r;

`ifdef CG_VBANK_PREV_PORT_EN
  logic [address_width-1:0] prev_ptr_r, prev_eff_s;
  logic                     prev_issue_s;
  logic [beat_width-1:0]    prev_data_r;
  logic                     prev_valid_r;

  // Previous-iteration read: own pointer, rewound by swap and rd_restart
  always_comb begin
    prev_issue_s = 1'b0;
    if (bus.rd_restart) begin
      prev_eff_s = '0;
    end else begin
      prev_eff_s = prev_ptr_r;
    end
    if (bus.prev_req && !bus.swap && !reset && (32'(prev_eff_s) < beats_r)) begin
      prev_issue_s = 1'b1;
    end else begin
      prev_issue_s = 1'b0;
    end
  end

  // Previous-iteration pointer and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_ptr_r   <= '0;
      prev_data_r  <= '0;
      prev_valid_r <= 1'b0;
    end else begin
      prev_valid_r <= prev_issue_s;
      if (bus.swap) begin
        prev_ptr_r <= '0;
      end else if (prev_issue_s) begin
        prev_ptr_r <= prev_eff_s + ptr_one;
      end else begin
        prev_ptr_r <= prev_eff_s;
      end
      if (prev_issue_s) begin
        prev_data_r <= mem_r[shadow_sel_s][idx_width'(prev_eff_s)];
      end else begin
        prev_data_r <= prev_data_r;
      end
    end
  end

  assign bus.prev_data  = prev_data_r;
  assign bus.prev_valid = prev_valid_r;
`else
  assign bus.prev_data  = '0;
  assign bus.prev_valid = 1'b0;
`endif
endmodule

// File: tb/tb_cg_vector_bank.sv
// Directed bench for cg_vector_bank: 8x8-bit beats, 16-deep banks, hand-computed expectations.
module tb_cg_vector_bank;
  localparam int EW = 8;
  localparam int NU = 8;
  localparam int MH = 16;

  localparam logic [63:0] BEAT_A = 64'hA0A1_A2A3_A4A5_A6A7;
  localparam logic [63:0] BEAT_B = 64'hB0B1_B2B3_B4B5_B6B7;
  localparam logic [63:0] BEAT_C = 64'hC0C1_C2C3_C4C5_C6C7;
  localparam logic [63:0] BEAT_D = 64'hD0D1_D2D3_D4D5_D6D7;
  localparam logic [63:0] BEAT_E = 64'hE0E1_E2E3_E4E5_E6E7;
  localparam logic [63:0] BEAT_X = 64'h5A5A_5A5A_5A5A_5A5A;
  localparam logic [63:0] BEAT_Z = 64'h1234_5678_9ABC_DEF0;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;

  cg_vector_bank_if #(.element_width(EW), .no_of_units(NU)) bus ();

  cg_vector_bank #(
    .element_width(EW),
    .no_of_units  (NU),
    .memory_height(MH)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.rd_req     = 1'b0;
    bus.rd_restart = 1'b0;
    bus.wr_en      = 1'b0;
    bus.wr_data    = '0;
    bus.swap       = 1'b0;
    bus.prev_req   = 1'b0;
  endtask

  task automatic write_beat(input logic [63:0] d);
    bus.wr_en   = 1'b1;
    bus.wr_data = d;
    tick();
    bus.wr_en   = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    idle_inputs();
    bus.total = 32'd16;
    reset = 1'b1;
    tick();
    tick();
    check("rst_rd_valid", 64'(bus.rd_valid), 64'd0);
    check("rst_rd_done", 64'(bus.rd_done), 64'd0);
    check("rst_wr_done", 64'(bus.wr_done), 64'd0);
    check("rst_overflow", 64'(bus.wr_overflow), 64'd0);
    check("rst_bank_sel", 64'(bus.bank_sel), 64'd0);
    check("rst_rd_data", bus.rd_data, 64'd0);
    check("rst_prev_valid", 64'(bus.prev_valid), 64'd0);
    reset = 1'b0;
    tick();

    // Fill shadow bank with A,B then swap and stream it out
    write_beat(BEAT_A);
    write_beat(BEAT_B);
    check("wr_done_after_2", 64'(bus.wr_done), 64'd1);
    bus.swap = 1'b1;
    tick();
    bus.swap = 1'b0;
    check("swap_bank_sel", 64'(bus.bank_sel), 64'd1);
    check("swap_wr_done_clr", 64'(bus.wr_done), 64'd0);
    bus.rd_req = 1'b1;
    tick();
    check("rd0_valid", 64'(bus.rd_valid), 64'd1);
    check("rd0_data", bus.rd_data, BEAT_A);
    check("rd0_done", 64'(bus.rd_done), 64'd0);
    tick();
    check("rd1_valid", 64'(bus.rd_valid), 64'd1);
    check("rd1_data", bus.rd_data, BEAT_B);
    check("rd1_done", 64'(bus.rd_done), 64'd1);
    tick();
    check("rd2_no_valid", 64'(bus.rd_valid), 64'd0);
    check("rd2_done_held", 64'(bus.rd_done), 64'd1);
    check("rd2_data_held", bus.rd_data, BEAT_B);
    bus.rd_req = 1'b0;

    // Rewind, then restart together with a strobe
    bus.rd_restart = 1'b1;
    tick();
    bus.rd_restart = 1'b0;
    check("restart_done_clr", 64'(bus.rd_done), 64'd0);
    bus.rd_req = 1'b1;
    tick();
    bus.rd_req = 1'b0;
    check("restart_rd_data", bus.rd_data, BEAT_A);
    check("restart_rd_done", 64'(bus.rd_done), 64'd0);
    bus.rd_req     = 1'b1;
    bus.rd_restart = 1'b1;
    tick();
    idle_inputs();
    check("restart_req_valid", 64'(bus.rd_valid), 64'd1);
    check("restart_req_data", bus.rd_data, BEAT_A);

    // Overflow: third write into a two-beat bank is dropped
    write_beat(BEAT_C);
    check("wr_done_after_1", 64'(bus.wr_done), 64'd0);
    write_beat(BEAT_D);
    check("wr_done_full", 64'(bus.wr_done), 64'd1);
    write_beat(BEAT_X);
    check("overflow_set", 64'(bus.wr_overflow), 64'd1);
    bus.swap = 1'b1;
    tick();
    bus.swap = 1'b0;
    check("swap2_bank_sel", 64'(bus.bank_sel), 64'd0);
    check("overflow_sticky", 64'(bus.wr_overflow), 64'd1);
    bus.rd_req = 1'b1;
    tick();
    check("ovf_rd0_data", bus.rd_data, BEAT_C);
    tick();
    bus.rd_req = 1'b0;
    check("ovf_rd1_data", bus.rd_data, BEAT_D);

    // Previous-iteration port: shadow holds A,B; overwrite beat 0 with E
    write_beat(BEAT_E);
    bus.prev_req = 1'b1;
    tick();
`ifdef CG_VBANK_PREV_PORT_EN
    check("prev0_valid", 64'(bus.prev_valid), 64'd1);
    check("prev0_data", bus.prev_data, BEAT_E);
`else
    check("prev0_valid_off", 64'(bus.prev_valid), 64'd0);
    check("prev0_data_off", bus.prev_data, 64'd0);
`endif
    tick();
    bus.prev_req = 1'b0;
`ifdef CG_VBANK_PREV_PORT_EN
    check("prev1_valid", 64'(bus.prev_valid), 64'd1);
    check("prev1_data", bus.prev_data, BEAT_B);
`else
    check("prev1_valid_off", 64'(bus.prev_valid), 64'd0);
`endif

    // Swap beats a simultaneous restart, read and write
    bus.swap       = 1'b1;
    bus.rd_req     = 1'b1;
    bus.rd_restart = 1'b1;
    bus.wr_en      = 1'b1;
    bus.wr_data    = BEAT_Z;
    tick();
    idle_inputs();
    check("swapwin_bank_sel", 64'(bus.bank_sel), 64'd1);
    check("swapwin_no_valid", 64'(bus.rd_valid), 64'd0);
    check("swapwin_done_clr", 64'(bus.rd_done), 64'd0);
    check("swapwin_wr_done", 64'(bus.wr_done), 64'd0);
    bus.rd_req = 1'b1;
    tick();
    check("swapwin_rd0", bus.rd_data, BEAT_E);
    tick();
    bus.rd_req = 1'b0;
    check("swapwin_rd1_dropped_wr", bus.rd_data, BEAT_B);
    write_beat(BEAT_A);
    check("swapwin_wrptr0_a", 64'(bus.wr_done), 64'd0);
    write_beat(BEAT_B);
    check("swapwin_wrptr0_b", 64'(bus.wr_done), 64'd1);

    // Zero-length vector
    bus.total = 32'd0;
    reset = 1'b1;
    tick();
    check("rst0_overflow_clr", 64'(bus.wr_overflow), 64'd0);
    check("rst0_rd_done", 64'(bus.rd_done), 64'd0);
    reset = 1'b0;
    tick();
    check("zero_rd_done", 64'(bus.rd_done), 64'd1);
    check("zero_wr_done", 64'(bus.wr_done), 64'd1);
    bus.rd_req = 1'b1;
    tick();
    bus.rd_req = 1'b0;
    check("zero_no_valid", 64'(bus.rd_valid), 64'd0);
    write_beat(BEAT_C);
    check("zero_overflow", 64'(bus.wr_overflow), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
